// File: rtl/core_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, port ownership
// and the default read data returned when a transaction times out.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_pick.sv
// Two-way selector between instruction and data requesters: fixed data
// priority, or round-robin against the previous grant.
module arb_pick
  import core_pkg::*;
#(
  parameter int DATA_RR = 0
) (
  input  logic   i_i_stb,
  input  logic   i_d_stb,
  input  owner_t last_grant,
  output owner_t owner
);

  // With no request at all the result is don't-care; the caller only uses it on a request.
  always_comb begin
    owner = OWN_I;
    if (i_i_stb && i_d_stb) begin
      if (DATA_RR != 0) begin
        owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
      end else begin
        owner = OWN_D;
      end
    end else if (i_d_stb) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported stb/ack memory between the instruction-fetch and
// data ports, one transaction at a time, with a per-transaction watchdog.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int          DATA_RR  = 0,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_i_stb,
  input  logic [31:0] i_i_addr,
  output logic        o_i_ack,
  output logic [31:0] o_i_data,
  input  logic        i_d_stb,
  input  logic        i_d_wr_en,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wr_data,
  output logic        o_d_ack,
  output logic [31:0] o_d_data,
  output logic        o_m_stb,
  output logic        o_m_wr_en,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wr_data,
  input  logic        i_m_ack,
  input  logic [31:0] i_m_data,
  output logic        o_err
);

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  owner_t        last_grant, last_grant_nxt;
  owner_t        pick;
  logic [CW-1:0] cnt, cnt_nxt;

  logic        i_ack_nxt, d_ack_nxt, err_nxt;
  logic [31:0] i_data_nxt, d_data_nxt;
  logic        m_stb_nxt, m_wr_en_nxt;
  logic [31:0] m_addr_nxt, m_wr_data_nxt;

  arb_pick #(.DATA_RR(DATA_RR)) u_pick (
    .i_i_stb    (i_i_stb),
    .i_d_stb    (i_d_stb),
    .last_grant (last_grant),
    .owner      (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_I;
      last_grant  <= OWN_I;
      cnt         <= '0;
      o_i_ack     <= 1'b0;
      o_d_ack     <= 1'b0;
      o_err       <= 1'b0;
      o_i_data    <= '0;
      o_d_data    <= '0;
      o_m_stb     <= 1'b0;
      o_m_wr_en   <= 1'b0;
      o_m_addr    <= '0;
      o_m_wr_data <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_grant  <= last_grant_nxt;
      cnt         <= cnt_nxt;
      o_i_ack     <= i_ack_nxt;
      o_d_ack     <= d_ack_nxt;
      o_err       <= err_nxt;
      o_i_data    <= i_data_nxt;
      o_d_data    <= d_data_nxt;
      o_m_stb     <= m_stb_nxt;
      o_m_wr_en   <= m_wr_en_nxt;
      o_m_addr    <= m_addr_nxt;
      o_m_wr_data <= m_wr_data_nxt;
    end
  end

  // Every output is a register; this block only computes next values, so acks
  // and o_err default low to make them single-cycle pulses.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    i_ack_nxt      = 1'b0;
    d_ack_nxt      = 1'b0;
    err_nxt        = 1'b0;
    i_data_nxt     = o_i_data;
    d_data_nxt     = o_d_data;
    m_stb_nxt      = o_m_stb;
    m_wr_en_nxt    = o_m_wr_en;
    m_addr_nxt     = o_m_addr;
    m_wr_data_nxt  = o_m_wr_data;

    case (state)
      ST_IDLE: begin
        if (i_i_stb || i_d_stb) begin
          owner_nxt = pick;
          if (pick == OWN_D) begin
            m_addr_nxt    = i_d_addr;
            m_wr_en_nxt   = i_d_wr_en;
            m_wr_data_nxt = i_d_wr_data;
          end else begin
            m_addr_nxt    = i_i_addr;
            m_wr_en_nxt   = 1'b0;
            m_wr_data_nxt = '0;
          end
          state_nxt = ST_GRANT;
        end
      end

      ST_GRANT: begin
        m_stb_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_BUSY;
      end

      ST_BUSY: begin
        if (cnt != {CW{1'b1}}) begin
          cnt_nxt = cnt + 1'b1;
        end
        // A memory ack on the last watchdog cycle still counts as a normal completion.
        if (i_m_ack) begin
          if (owner == OWN_D) begin
            d_ack_nxt = 1'b1;
            if (!o_m_wr_en) begin
              d_data_nxt = i_m_data;
            end
          end else begin
            i_ack_nxt  = 1'b1;
            i_data_nxt = i_m_data;
          end
          m_stb_nxt = 1'b0;
          state_nxt = ST_RESP;
        end else if ((TIMEOUT > 0) && (cnt == TO_LAST)) begin
          if (owner == OWN_D) begin
            d_ack_nxt  = 1'b1;
            d_data_nxt = ERR_DATA;
          end else begin
            i_ack_nxt  = 1'b1;
            i_data_nxt = ERR_DATA;
          end
          err_nxt   = 1'b1;
          m_stb_nxt = 1'b0;
          state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        last_grant_nxt = owner;
        state_nxt      = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut0 uses fixed data priority, dut1 round-robin; both TIMEOUT=8.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic        i_stb[2];
  logic [31:0] i_addr[2];
  logic        i_ack[2];
  logic [31:0] i_data[2];
  logic        d_stb[2];
  logic        d_wr[2];
  logic [31:0] d_addr[2];
  logic [31:0] d_wdata[2];
  logic        d_ack[2];
  logic [31:0] d_data[2];
  logic        m_stb[2];
  logic        m_wr[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  logic        m_ack[2];
  logic [31:0] m_data[2];
  logic        err[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_RR(0), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut0 (
    .clk(clk), .rst(rst),
    .i_i_stb(i_stb[0]), .i_i_addr(i_addr[0]), .o_i_ack(i_ack[0]), .o_i_data(i_data[0]),
    .i_d_stb(d_stb[0]), .i_d_wr_en(d_wr[0]), .i_d_addr(d_addr[0]), .i_d_wr_data(d_wdata[0]),
    .o_d_ack(d_ack[0]), .o_d_data(d_data[0]),
    .o_m_stb(m_stb[0]), .o_m_wr_en(m_wr[0]), .o_m_addr(m_addr[0]), .o_m_wr_data(m_wdata[0]),
    .i_m_ack(m_ack[0]), .i_m_data(m_data[0]), .o_err(err[0])
  );

  mem_port_arbiter #(.DATA_RR(1), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut1 (
    .clk(clk), .rst(rst),
    .i_i_stb(i_stb[1]), .i_i_addr(i_addr[1]), .o_i_ack(i_ack[1]), .o_i_data(i_data[1]),
    .i_d_stb(d_stb[1]), .i_d_wr_en(d_wr[1]), .i_d_addr(d_addr[1]), .i_d_wr_data(d_wdata[1]),
    .o_d_ack(d_ack[1]), .o_d_data(d_data[1]),
    .o_m_stb(m_stb[1]), .o_m_wr_en(m_wr[1]), .o_m_addr(m_addr[1]), .o_m_wr_data(m_wdata[1]),
    .i_m_ack(m_ack[1]), .i_m_data(m_data[1]), .o_err(err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int p, input logic is_d, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (is_d) begin
      d_stb[p]   = 1'b1;
      d_wr[p]    = wr;
      d_addr[p]  = addr;
      d_wdata[p] = wdata;
    end else begin
      i_stb[p]  = 1'b1;
      i_addr[p] = addr;
    end
  endtask

  // Waits (bounded) for the memory request; n is the number of cycles it took.
  task automatic waitMemStb(input int p, input string tag, output int n);
    n = 0;
    while (!m_stb[p] && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, " m_stb"}, 32'(m_stb[p]), 32'd1);
  endtask

  // One arbitration round: memory acks on the first BUSY cycle; the owner then
  // drops its strobe and, if asked, raises it again in the IDLE cycle.
  task automatic arbRound(input int p, input int k, input logic exp_d, input logic again);
    int    n;
    string tag;
    tag = $sformatf("arb%0d_%0d", p, k);
    waitMemStb(p, tag, n);
    checkOutput({tag, " addr"}, m_addr[p], exp_d ? 32'hD0 : 32'h10);
    m_ack[p]  = 1'b1;
    m_data[p] = 32'h1000 + 32'(k);
    tick();
    m_ack[p] = 1'b0;
    checkOutput({tag, " d_ack"}, 32'(d_ack[p]), 32'(exp_d));
    checkOutput({tag, " i_ack"}, 32'(i_ack[p]), 32'(!exp_d));
    checkOutput({tag, " data"}, exp_d ? d_data[p] : i_data[p], 32'h1000 + 32'(k));
    if (exp_d) d_stb[p] = 1'b0;
    else       i_stb[p] = 1'b0;
    tick();
    if (again) applyStimulus(p, exp_d, 1'b0, exp_d ? 32'hD0 : 32'h10, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int n;
    for (int p = 0; p < 2; p++) begin
      i_stb[p] = 0; i_addr[p] = 0; d_stb[p] = 0; d_wr[p] = 0;
      d_addr[p] = 0; d_wdata[p] = 0; m_ack[p] = 0; m_data[p] = 0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst i_ack",   32'(i_ack[0]), 32'd0);
    checkOutput("rst d_ack",   32'(d_ack[0]), 32'd0);
    checkOutput("rst err",     32'(err[0]),   32'd0);
    checkOutput("rst m_stb",   32'(m_stb[0]), 32'd0);
    checkOutput("rst m_wr",    32'(m_wr[0]),  32'd0);
    checkOutput("rst m_addr",  m_addr[0],     32'd0);
    checkOutput("rst i_data",  i_data[0],     32'd0);
    checkOutput("rst d_data",  d_data[0],     32'd0);

    // Single instruction read, memory acks two cycles after the request appears
    applyStimulus(0, 1'b0, 1'b0, 32'h100, 32'h0);
    waitMemStb(0, "iread", n);
    checkOutput("iread latency", 32'(n), 32'd2);
    checkOutput("iread m_addr", m_addr[0], 32'h100);
    checkOutput("iread m_wr",   32'(m_wr[0]), 32'd0);
    tick();
    tick();
    m_ack[0]  = 1'b1;
    m_data[0] = 32'h0050_0093;
    tick();
    m_ack[0] = 1'b0;
    i_stb[0] = 1'b0;
    checkOutput("iread i_ack",  32'(i_ack[0]), 32'd1);
    checkOutput("iread i_data", i_data[0], 32'h0050_0093);
    checkOutput("iread d_ack",  32'(d_ack[0]), 32'd0);
    checkOutput("iread m_stb",  32'(m_stb[0]), 32'd0);
    tick();
    checkOutput("iread ack pulse", 32'(i_ack[0]), 32'd0);
    checkOutput("iread data hold", i_data[0], 32'h0050_0093);

    // Data write; requester fields change after latching and must not leak through
    applyStimulus(0, 1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D);
    waitMemStb(0, "dwrite", n);
    checkOutput("dwrite m_wr",    32'(m_wr[0]), 32'd1);
    checkOutput("dwrite m_addr",  m_addr[0],  32'h2000);
    checkOutput("dwrite m_wdata", m_wdata[0], 32'hCAFE_F00D);
    d_addr[0]  = 32'h9999;
    d_wdata[0] = 32'h0;
    tick();
    checkOutput("dwrite addr stable",  m_addr[0],  32'h2000);
    checkOutput("dwrite wdata stable", m_wdata[0], 32'hCAFE_F00D);
    m_ack[0]  = 1'b1;
    m_data[0] = 32'h1234_5678;
    tick();
    m_ack[0] = 1'b0;
    d_stb[0] = 1'b0;
    checkOutput("dwrite d_ack",  32'(d_ack[0]), 32'd1);
    checkOutput("dwrite d_data", d_data[0], 32'h0);
    checkOutput("dwrite i_ack",  32'(i_ack[0]), 32'd0);
    tick();
    checkOutput("dwrite ack pulse", 32'(d_ack[0]), 32'd0);

    // Fixed priority: I held throughout, D re-requests once -> D, D, I
    applyStimulus(0, 1'b1, 1'b0, 32'hD0, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
    arbRound(0, 0, 1'b1, 1'b1);
    arbRound(0, 1, 1'b1, 1'b0);
    arbRound(0, 2, 1'b0, 1'b0);

    // Round-robin: both keep re-requesting -> D, I, D, I
    applyStimulus(1, 1'b1, 1'b0, 32'hD0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      arbRound(1, k, (k % 2) == 0, k < 2);
    end

    // Watchdog: memory never acks, then a late ack must be ignored
    applyStimulus(0, 1'b1, 1'b0, 32'h300, 32'h0);
    waitMemStb(0, "tmo", n);
    n = 0;
    while (m_stb[0] && n < 20) begin
      n++;
      tick();
    end
    checkOutput("tmo busy cycles", 32'(n), 32'd8);
    checkOutput("tmo d_ack",  32'(d_ack[0]), 32'd1);
    checkOutput("tmo err",    32'(err[0]),   32'd1);
    checkOutput("tmo d_data", d_data[0], 32'hDEAD_BEEF);
    checkOutput("tmo i_ack",  32'(i_ack[0]), 32'd0);
    m_ack[0] = 1'b1;
    d_stb[0] = 1'b0;
    tick();
    checkOutput("tmo late d_ack", 32'(d_ack[0]), 32'd0);
    checkOutput("tmo late err",   32'(err[0]),   32'd0);
    checkOutput("tmo data hold",  d_data[0], 32'hDEAD_BEEF);
    tick();
    checkOutput("tmo late2 d_ack", 32'(d_ack[0]), 32'd0);
    checkOutput("tmo late2 m_stb", 32'(m_stb[0]), 32'd0);
    m_ack[0] = 1'b0;

    // Ack on the last watchdog cycle wins over the timeout
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0);
    waitMemStb(0, "edge", n);
    repeat (7) tick();
    checkOutput("edge m_stb still", 32'(m_stb[0]), 32'd1);
    m_ack[0]  = 1'b1;
    m_data[0] = 32'h0BAD_F00D;
    tick();
    m_ack[0] = 1'b0;
    d_stb[0] = 1'b0;
    checkOutput("edge d_ack",  32'(d_ack[0]), 32'd1);
    checkOutput("edge err",    32'(err[0]),   32'd0);
    checkOutput("edge d_data", d_data[0], 32'h0BAD_F00D);
    tick();

    // Reset while BUSY abandons the transaction; a stale ack afterwards is ignored
    applyStimulus(0, 1'b0, 1'b0, 32'h500, 32'h0);
    waitMemStb(0, "rstbusy", n);
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    i_stb[0] = 1'b0;
    m_ack[0] = 1'b1;
    m_data[0] = 32'h5555_AAAA;
    checkOutput("rstbusy m_stb",  32'(m_stb[0]), 32'd0);
    checkOutput("rstbusy i_ack",  32'(i_ack[0]), 32'd0);
    checkOutput("rstbusy m_addr", m_addr[0], 32'd0);
    tick();
    checkOutput("rstbusy stale i_ack", 32'(i_ack[0]), 32'd0);
    checkOutput("rstbusy stale d_ack", 32'(d_ack[0]), 32'd0);
    checkOutput("rstbusy stale m_stb", 32'(m_stb[0]), 32'd0);
    m_ack[0] = 1'b0;
    tick();
    checkOutput("rstbusy i_data", i_data[0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
